// File: rtl/apb_arbiter2.sv
// Two-initiator APB arbiter: one owner at a time, request-window ownership,
// round-robin tie break and a PREADY watchdog that aborts stalled access phases.
module apb_arbiter2 #(
  parameter logic [7:0] TIMEOUT = 8'd64
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       m0_req,
  input  logic       m1_req,
  output logic       m0_gnt,
  output logic       m1_gnt,
  input  logic       m0_PSEL,
  input  logic       m0_PENABLE,
  input  logic       m0_PWRITE,
  input  logic [7:0] m0_PADDR,
  input  logic [7:0] m0_PWDATA,
  output logic [7:0] m0_PRDATA,
  output logic       m0_PREADY,
  input  logic       m1_PSEL,
  input  logic       m1_PENABLE,
  input  logic       m1_PWRITE,
  input  logic [7:0] m1_PADDR,
  input  logic [7:0] m1_PWDATA,
  output logic [7:0] m1_PRDATA,
  output logic       m1_PREADY,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       PREADY,
  output logic       timeout_err,
  input  logic       err_clr
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic WD_EN = (TIMEOUT != 8'd0);

  state_t     state, state_nxt;
  logic       last_served, last_served_nxt;
  logic [7:0] wd_cnt, wd_cnt_nxt;
  logic       own_psel, own_penable, own_pwrite;
  logic [7:0] own_paddr, own_pwdata;
  logic       stall, abort;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state       <= IDLE;
      last_served <= 1'b1;
      wd_cnt      <= 8'd0;
      m0_gnt      <= 1'b0;
      m1_gnt      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
      wd_cnt      <= wd_cnt_nxt;
      m0_gnt      <= (state_nxt == OWN0);
      m1_gnt      <= (state_nxt == OWN1);
      if (abort)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
    end
  end

  // An owner is released only once both its request and any in-flight PSEL are gone.
  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    case (state)
      IDLE: begin
        if (m0_req && (!m1_req || last_served)) begin
          state_nxt       = OWN0;
          last_served_nxt = 1'b0;
        end else if (m1_req) begin
          state_nxt       = OWN1;
          last_served_nxt = 1'b1;
        end
      end
      OWN0: begin
        if (!m0_req && !m0_PSEL) begin
          if (m1_req) begin
            state_nxt       = OWN1;
            last_served_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      OWN1: begin
        if (!m1_req && !m1_PSEL) begin
          if (m0_req) begin
            state_nxt       = OWN0;
            last_served_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    own_psel    = 1'b0;
    own_penable = 1'b0;
    own_pwrite  = 1'b0;
    own_paddr   = 8'd0;
    own_pwdata  = 8'd0;
    case (state)
      OWN0: begin
        own_psel    = m0_PSEL;
        own_penable = m0_PENABLE;
        own_pwrite  = m0_PWRITE;
        own_paddr   = m0_PADDR;
        own_pwdata  = m0_PWDATA;
      end
      OWN1: begin
        own_psel    = m1_PSEL;
        own_penable = m1_PENABLE;
        own_pwrite  = m1_PWRITE;
        own_paddr   = m1_PADDR;
        own_pwdata  = m1_PWDATA;
      end
      default: ;
    endcase
  end

  // Abort cycle fakes a completion to the owner and hides the access from the target.
  assign stall = own_psel & own_penable & ~PREADY;
  assign abort = WD_EN & stall & (wd_cnt == TIMEOUT);

  assign PSEL    = own_psel & ~abort;
  assign PENABLE = own_penable & ~abort;
  assign PWRITE  = own_pwrite;
  assign PADDR   = own_paddr;
  assign PWDATA  = own_pwdata;

  assign m0_PREADY = (state == OWN0) & (PREADY | abort);
  assign m1_PREADY = (state == OWN1) & (PREADY | abort);
  assign m0_PRDATA = (state != OWN0) ? 8'd0 : (abort ? 8'hFF : PRDATA);
  assign m1_PRDATA = (state != OWN1) ? 8'd0 : (abort ? 8'hFF : PRDATA);

  always_comb begin
    wd_cnt_nxt = wd_cnt;
    if (!WD_EN || (state_nxt != state) || PREADY || abort)
      wd_cnt_nxt = 8'd0;
    else if (stall && (wd_cnt != 8'hFF))
      wd_cnt_nxt = wd_cnt + 8'd1;
  end

endmodule

// File: tb/tb_apb_arbiter2.sv
// Bench for apb_arbiter2: directed scenarios followed by randomized bursts from
// both initiators, checked against a shadow memory and transaction-level rules.
module tb_apb_arbiter2;

  logic       CLK = 1'b0;
  logic       RESETn = 1'b0;
  logic       m0_req = 1'b0, m1_req = 1'b0;
  logic       m0_gnt, m1_gnt;
  logic       m0_PSEL = 1'b0, m0_PENABLE = 1'b0, m0_PWRITE = 1'b0;
  logic [7:0] m0_PADDR = 8'd0, m0_PWDATA = 8'd0;
  logic [7:0] m0_PRDATA;
  logic       m0_PREADY;
  logic       m1_PSEL = 1'b0, m1_PENABLE = 1'b0, m1_PWRITE = 1'b0;
  logic [7:0] m1_PADDR = 8'd0, m1_PWDATA = 8'd0;
  logic [7:0] m1_PRDATA;
  logic       m1_PREADY;
  logic       PSEL, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic [7:0] PRDATA = 8'd0;
  logic       PREADY = 1'b0;
  logic       timeout_err;
  logic       err_clr = 1'b0;

  apb_arbiter2 #(.TIMEOUT(8'd4)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .m0_req(m0_req), .m1_req(m1_req), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_PSEL(m0_PSEL), .m0_PENABLE(m0_PENABLE), .m0_PWRITE(m0_PWRITE),
    .m0_PADDR(m0_PADDR), .m0_PWDATA(m0_PWDATA), .m0_PRDATA(m0_PRDATA), .m0_PREADY(m0_PREADY),
    .m1_PSEL(m1_PSEL), .m1_PENABLE(m1_PENABLE), .m1_PWRITE(m1_PWRITE),
    .m1_PADDR(m1_PADDR), .m1_PWDATA(m1_PWDATA), .m1_PRDATA(m1_PRDATA), .m1_PREADY(m1_PREADY),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 CLK = ~CLK;

  typedef struct {bit wr; logic [7:0] addr; logic [7:0] data;} xfer_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] tgt_mem [256];
  logic [7:0] shadow [256];
  xfer_t      tgt_log [$];
  int         tgt_wait = 0;
  bit         tgt_hang = 1'b0;
  bit         rand_wait = 1'b0;
  bit         mon_en = 1'b0;
  logic [7:0] rd_a, rd_b;
  bit         ok_a, ok_b;
  int         n0, n1, stalls;

  // Target model: memory with per-access wait states, updated shortly after each rising edge.
  initial begin
    int wcnt;
    int cur;
    wcnt = 0;
    cur  = 0;
    forever begin
      @(posedge CLK);
      #2;
      if (PSEL && PENABLE && !tgt_hang) begin
        if (wcnt == 0) cur = rand_wait ? $urandom_range(0, 3) : tgt_wait;
        if (wcnt >= cur) begin
          PREADY = 1'b1;
          if (PWRITE) begin
            tgt_mem[PADDR] = PWDATA;
            PRDATA = 8'd0;
          end else begin
            PRDATA = tgt_mem[PADDR];
          end
          tgt_log.push_back('{PWRITE, PADDR, PWDATA});
        end else begin
          PREADY = 1'b0;
          PRDATA = 8'($urandom);
        end
        wcnt++;
      end else begin
        PREADY = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        checks++;
        assert (!(m0_gnt && m1_gnt) && !(m0_PREADY && !m0_gnt) && !(m1_PREADY && !m1_gnt))
        else begin
          errors++;
          $error("[TB] FAIL isolation: observed gnt=%b%b rdy=%b%b expected exclusive owner", m1_gnt, m0_gnt, m1_PREADY, m0_PREADY);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: observed still running, expected finished");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input bit s, input bit e, input bit w,
                       input logic [7:0] a, input logic [7:0] d);
    if (m == 0) begin
      m0_PSEL = s; m0_PENABLE = e; m0_PWRITE = w; m0_PADDR = a; m0_PWDATA = d;
    end else begin
      m1_PSEL = s; m1_PENABLE = e; m1_PWRITE = w; m1_PADDR = a; m1_PWDATA = d;
    end
  endtask

  task automatic set_req(input int m, input bit v);
    if (m == 0) m0_req = v;
    else        m1_req = v;
  endtask

  function automatic logic get_rdy(input int m);
    return (m == 0) ? m0_PREADY : m1_PREADY;
  endfunction

  function automatic logic [7:0] get_rd(input int m);
    return (m == 0) ? m0_PRDATA : m1_PRDATA;
  endfunction

  function automatic logic get_gnt(input int m);
    return (m == 0) ? m0_gnt : m1_gnt;
  endfunction

  task automatic wait_gnt(input int m, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (get_gnt(m)) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  // One APB transfer; returns one cycle after the completing edge with PSEL low.
  task automatic xfer(input int m, input bit wr, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output bit ok);
    ok = 1'b0;
    rd = 8'd0;
    drive(m, 1'b1, 1'b0, wr, a, d);
    @(posedge CLK);
    #1;
    drive(m, 1'b1, 1'b1, wr, a, d);
    for (int n = 0; n < 300; n++) begin
      @(negedge CLK);
      if (get_rdy(m)) begin
        rd = get_rd(m);
        ok = 1'b1;
        break;
      end
    end
    @(posedge CLK);
    #1;
    drive(m, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic go_idle();
    m0_req = 1'b0;
    m1_req = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    go_idle();
    RESETn = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESETn = 1'b1;
  endtask

  // Random initiator: optional delay, then an atomic burst confined to its half of the address map.
  task automatic applyStimulus(input int m, input bit en, input int dly, input int len, output int issued);
    logic [7:0] a, d, rd;
    bit         wr, ok;
    issued = 0;
    if (en) begin
      repeat (dly) @(posedge CLK);
      if (dly > 0) #1;
      set_req(m, 1'b1);
      wait_gnt(m, ok);
      checkOutput("rnd_gnt", 8'(ok), 8'd1);
      for (int i = 0; i < len; i++) begin
        wr = 1'($urandom_range(0, 1));
        a  = (m == 0) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
        d  = 8'($urandom);
        xfer(m, wr, a, d, rd, ok);
        checkOutput("rnd_xfer_done", 8'(ok), 8'd1);
        issued++;
        if (wr) shadow[a] = d;
        else    checkOutput("rnd_read", rd, shadow[a]);
      end
      set_req(m, 1'b0);
    end
  endtask

  initial begin
    bit en0, en1;
    int d0, d1, l0, l1, sw;

    for (int i = 0; i < 256; i++) tgt_mem[i] = 8'($urandom);

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_m0_gnt", 8'(m0_gnt), 8'd0);
    checkOutput("rst_m1_gnt", 8'(m1_gnt), 8'd0);
    checkOutput("rst_psel", 8'(PSEL), 8'd0);
    checkOutput("rst_paddr", PADDR, 8'd0);
    checkOutput("rst_err", 8'(timeout_err), 8'd0);
    @(posedge CLK);
    #1;
    RESETn = 1'b1;

    // Single write from m0 with setup and access phases visible at the target.
    @(posedge CLK);
    #1;
    m0_req = 1'b1;
    @(negedge CLK);
    checkOutput("t1_gnt_early", 8'(m0_gnt), 8'd0);
    @(posedge CLK);
    #1;
    drive(0, 1'b1, 1'b0, 1'b1, 8'h10, 8'hA5);
    @(negedge CLK);
    checkOutput("t1_gnt", 8'(m0_gnt), 8'd1);
    checkOutput("t1_setup_psel", 8'(PSEL), 8'd1);
    checkOutput("t1_setup_pen", 8'(PENABLE), 8'd0);
    checkOutput("t1_paddr", PADDR, 8'h10);
    checkOutput("t1_pwdata", PWDATA, 8'hA5);
    checkOutput("t1_pwrite", 8'(PWRITE), 8'd1);
    @(posedge CLK);
    #1;
    drive(0, 1'b1, 1'b1, 1'b1, 8'h10, 8'hA5);
    @(negedge CLK);
    checkOutput("t1_access_pen", 8'(PENABLE), 8'd1);
    checkOutput("t1_m0_ready", 8'(m0_PREADY), 8'd1);
    checkOutput("t1_m1_ready", 8'(m1_PREADY), 8'd0);
    @(posedge CLK);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    m0_req = 1'b0;
    @(negedge CLK);
    checkOutput("t1_mem", tgt_mem[8'h10], 8'hA5);
    go_idle();

    // Ties alternate; handover on release skips IDLE.
    do_reset();
    m0_req = 1'b1;
    m1_req = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("t2_tieA_m0", 8'(m0_gnt), 8'd1);
    checkOutput("t2_tieA_m1", 8'(m1_gnt), 8'd0);
    @(posedge CLK);
    #1;
    m0_req = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("t2_hand_m1", 8'(m1_gnt), 8'd1);
    checkOutput("t2_hand_m0", 8'(m0_gnt), 8'd0);
    @(posedge CLK);
    #1;
    m1_req = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("t2_idle", 8'({m1_gnt, m0_gnt}), 8'd0);
    @(posedge CLK);
    #1;
    m0_req = 1'b1;
    m1_req = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("t2_tieB_m0", 8'({m1_gnt, m0_gnt}), 8'd1);
    @(posedge CLK);
    #1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    @(posedge CLK);
    #1;
    m0_req = 1'b1;
    m1_req = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("t2_tieC_m1", 8'({m1_gnt, m0_gnt}), 8'd2);
    go_idle();

    // m0 drops req mid-read with wait states; ownership holds until completion.
    tgt_mem[8'h20] = 8'h5C;
    tgt_wait = 3;
    m0_req = 1'b1;
    @(posedge CLK);
    #1;
    m1_req = 1'b1;
    drive(0, 1'b1, 1'b0, 1'b0, 8'h20, 8'd0);
    @(posedge CLK);
    #1;
    drive(0, 1'b1, 1'b1, 1'b0, 8'h20, 8'd0);
    m0_req = 1'b0;
    stalls = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK);
      if (m0_PREADY) break;
      checkOutput("t3_hold_m1", 8'(m1_gnt), 8'd0);
      stalls++;
    end
    checkOutput("t3_stalls", 8'(stalls), 8'd3);
    checkOutput("t3_rdata", m0_PRDATA, 8'h5C);
    checkOutput("t3_still_m0", 8'(m0_gnt), 8'd1);
    @(posedge CLK);
    #1;
    drive(0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("t3_m1_gnt", 8'({m1_gnt, m0_gnt}), 8'd2);
    tgt_wait = 0;
    go_idle();

    // Watchdog abort, then clear, then set-wins-over-clear.
    tgt_hang = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m0_req = 1'b1;
      @(posedge CLK);
      #1;
      drive(0, 1'b1, 1'b0, 1'b0, 8'h40, 8'd0);
      @(posedge CLK);
      #1;
      drive(0, 1'b1, 1'b1, 1'b0, 8'h40, 8'd0);
      err_clr = (k == 1);
      stalls = 0;
      for (int n = 0; n < 20; n++) begin
        @(negedge CLK);
        if (m0_PREADY) break;
        stalls++;
      end
      checkOutput("t4_stalls", 8'(stalls), 8'd4);
      checkOutput("t4_abort_rdata", m0_PRDATA, 8'hFF);
      checkOutput("t4_abort_psel", 8'(PSEL), 8'd0);
      checkOutput("t4_abort_pen", 8'(PENABLE), 8'd0);
      checkOutput("t4_err_pre", 8'(timeout_err), 8'd0);
      @(posedge CLK);
      #1;
      err_clr = 1'b0;
      drive(0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      m0_req = 1'b0;
      @(negedge CLK);
      checkOutput("t4_err_set", 8'(timeout_err), 8'd1);
      if (k == 0) begin
        @(posedge CLK);
        #1;
        err_clr = 1'b1;
        @(posedge CLK);
        #1;
        err_clr = 1'b0;
        @(negedge CLK);
        checkOutput("t4_err_clr", 8'(timeout_err), 8'd0);
        @(posedge CLK);
        #1;
      end
    end
    tgt_hang = 1'b0;
    go_idle();

    // m1 starts early while m0 runs a 4-write burst; target sees m0 first, then m1.
    tgt_mem[8'h33] = 8'h77;
    tgt_log.delete();
    fork
      begin
        m0_req = 1'b1;
        wait_gnt(0, ok_a);
        checkOutput("t5_m0_gnt", 8'(ok_a), 8'd1);
        for (int i = 0; i < 4; i++) begin
          xfer(0, 1'b1, 8'h50 + 8'(i), 8'hC0 + 8'(i), rd_a, ok_a);
          checkOutput("t5_m0_done", 8'(ok_a), 8'd1);
        end
        m0_req = 1'b0;
      end
      begin
        repeat (3) @(posedge CLK);
        #1;
        m1_req = 1'b1;
        xfer(1, 1'b0, 8'h33, 8'd0, rd_b, ok_b);
        m1_req = 1'b0;
      end
    join
    checkOutput("t5_m1_done", 8'(ok_b), 8'd1);
    checkOutput("t5_m1_rdata", rd_b, 8'h77);
    checkOutput("t5_log_size", 8'(tgt_log.size()), 8'd5);
    if (tgt_log.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput("t5_log_addr", tgt_log[i].addr, 8'h50 + 8'(i));
        checkOutput("t5_log_data", tgt_log[i].data, 8'hC0 + 8'(i));
        checkOutput("t5_log_wr", 8'(tgt_log[i].wr), 8'd1);
      end
      checkOutput("t5_log_m1_addr", tgt_log[4].addr, 8'h33);
      checkOutput("t5_log_m1_wr", 8'(tgt_log[4].wr), 8'd0);
    end
    go_idle();

    // Asynchronous reset in the middle of a stalled access.
    tgt_hang = 1'b1;
    m0_req = 1'b1;
    wait_gnt(0, ok_a);
    drive(0, 1'b1, 1'b0, 1'b0, 8'h60, 8'd0);
    @(posedge CLK);
    #1;
    drive(0, 1'b1, 1'b1, 1'b0, 8'h60, 8'd0);
    @(negedge CLK);
    checkOutput("t6_psel_pre", 8'(PSEL), 8'd1);
    checkOutput("t6_err_pre", 8'(timeout_err), 8'd1);
    #1;
    RESETn = 1'b0;
    #1;
    checkOutput("t6_psel", 8'(PSEL), 8'd0);
    checkOutput("t6_pen", 8'(PENABLE), 8'd0);
    checkOutput("t6_gnt", 8'({m1_gnt, m0_gnt}), 8'd0);
    checkOutput("t6_err", 8'(timeout_err), 8'd0);
    m0_req = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    tgt_hang = 1'b0;
    @(posedge CLK);
    #1;
    RESETn = 1'b1;
    m0_req = 1'b1;
    m1_req = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("t6_tie_m0", 8'({m1_gnt, m0_gnt}), 8'd1);
    go_idle();

    // Randomized concurrent bursts against the shadow memory.
    for (int i = 0; i < 256; i++) shadow[i] = tgt_mem[i];
    rand_wait = 1'b1;
    mon_en = 1'b1;
    for (int r = 0; r < 40; r++) begin
      en0 = ($urandom_range(0, 2) != 0);
      en1 = ($urandom_range(0, 2) != 0);
      if (!en0 && !en1) en0 = 1'b1;
      d0 = $urandom_range(0, 3);
      d1 = $urandom_range(0, 3);
      l0 = $urandom_range(1, 4);
      l1 = $urandom_range(1, 4);
      tgt_log.delete();
      fork
        applyStimulus(0, en0, d0, l0, n0);
        applyStimulus(1, en1, d1, l1, n1);
      join
      checkOutput("rnd_count", 8'(tgt_log.size()), 8'(n0 + n1));
      sw = 0;
      for (int i = 1; i < tgt_log.size(); i++)
        if (tgt_log[i].addr[7] != tgt_log[i-1].addr[7]) sw++;
      checkOutput("rnd_atomic", 8'(sw <= 1), 8'd1);
      go_idle();
    end
    mon_en = 1'b0;
    for (int i = 0; i < 256; i++) checkOutput("rnd_mem", tgt_mem[i], shadow[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_arbiter2.md
Name: apb_arbiter2

Overview:
- Shares one 8-bit APB target bus between two APB initiators.
- Typical initiators: two stream-to-APB bridges, e.g. a host-link bridge and a debug bridge.
- Ownership is granted per request window. An owner keeps the bus while its req is high, so multi-transfer bursts stay atomic.
- A watchdog aborts access phases that stall on PREADY, so a hung peripheral cannot lock out both initiators.

Parameters:
- TIMEOUT, 8'd64, access-phase cycles with PREADY low before abort; 0 disables the watchdog; valid range 0..255.

Ports:
- CLK  in  1  clock
- RESETn  in  1  asynchronous active-low reset
- m0_req, m1_req  in  1  request/hold bus (e.g. bridge busy)
- m0_gnt, m1_gnt  out  1  registered grant
- m0_PSEL, m1_PSEL  in  1  initiator APB select
- m0_PENABLE, m1_PENABLE  in  1  initiator APB enable
- m0_PWRITE, m1_PWRITE  in  1  initiator APB write
- m0_PADDR, m1_PADDR  in  8  initiator address
- m0_PWDATA, m1_PWDATA  in  8  initiator write data
- m0_PRDATA, m1_PRDATA  out  8  read data returned to initiator
- m0_PREADY, m1_PREADY  out  1  ready returned to initiator
- PSEL, PENABLE, PWRITE  out  1  target bus controls
- PADDR, PWDATA  out  8  target bus address/data
- PRDATA  in  8  target read data
- PREADY  in  1  target ready
- timeout_err  out  1  sticky watchdog flag
- err_clr  in  1  clears timeout_err

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; m0_gnt=m1_gnt=0; timeout_err=0; timeout counter 0.
  - Last-served pointer=1, so m0 wins the first tie.
  - All target outputs 0.
- States:
  - IDLE: no owner.
  - OWN0: m0 owns the bus.
  - OWN1: m1 owns the bus.
- Grants are one-hot or zero: m0_gnt=(state==OWN0), m1_gnt=(state==OWN1). They are registered, so grant lands one cycle after req is sampled.
- IDLE transitions:
  - Only m0_req -> OWN0.
  - Only m1_req -> OWN1.
  - Both -> the initiator not equal to last-served.
  - Entering OWNn sets last-served=n.
- OWNn holds while mn_req=1 or mn_PSEL=1. An in-flight transfer always completes, even if req drops.
- OWNn release, when mn_req=0 and mn_PSEL=0:
  - Other req high -> OWN(other) directly, no IDLE bubble; last-served updates.
  - Otherwise -> IDLE.
- Mux (combinational from registered state):
  - Target PSEL/PENABLE/PWRITE/PADDR/PWDATA = owner's signals.
  - In IDLE all target outputs are 0.
  - Owner's mn_PREADY=PREADY and mn_PRDATA=PRDATA.
- Non-owner isolation:
  - Non-owner sees mn_PREADY=0 and mn_PRDATA=0. Its PSEL is never forwarded; it simply stalls.
  - An initiator must not begin a transfer before gnt. If it does, the transfer stalls until grant and then proceeds.
- Watchdog, active only when TIMEOUT!=0:
  - Counter increments each cycle with target PSEL&PENABLE&~PREADY. It clears on PREADY=1 or ownership change.
  - When counter==TIMEOUT, that cycle is an abort cycle:
    - Owner sees mn_PREADY=1 and mn_PRDATA=8'hFF.
    - Target PSEL and PENABLE are forced to 0.
    - timeout_err<=1; counter<=0.
  - Counter is 8 bits and saturates; no wrap.
- timeout_err:
  - Stays set until err_clr=1 at a clock edge.
  - A simultaneous set and err_clr leaves it set (set wins).
- Reset mid-transfer: the bus goes idle immediately (async). Initiators are expected to be reset by the same RESETn.
- Throughput: the owner gets back-to-back transfers with zero arbitration overhead. APB setup/access timing passes through unchanged.

Test Plan:
- m0_req=1 from IDLE; m0 writes 8'h10<-8'hA5 with PREADY=1 -> m0_gnt=1 one cycle after req; target sees PADDR=8'h10, PWDATA=8'hA5, PWRITE=1 with setup then access phase; m1_PREADY stays 0.
- m0_req and m1_req asserted in the same cycle after reset -> m0 granted; after m0_req drops, m1_gnt=1 on the next edge with no IDLE cycle. Repeat the tie -> m1 then m0 order alternates (m0 first, then m1 wins the following tie).
- m0 owns the bus and drops m0_req while a read to 8'h20 waits 3 cycles on PREADY; m1_req=1 throughout -> m0 keeps ownership until its PENABLE&PREADY cycle returns PRDATA=8'h5C, then m1_gnt=1.
- TIMEOUT=4; target holds PREADY=0 -> after 4 stalled access cycles, owner gets PREADY=1 and PRDATA=8'hFF, target PSEL=0, timeout_err=1. err_clr pulse -> timeout_err=0. Set and clear in the same cycle -> stays 1.
- m1 asserts m1_PSEL with PADDR=8'h33 while m0 owns a 4-write burst -> target sees only m0's 4 writes; m1 completes its transfer after handover with correct PRDATA.
- RESETn pulsed low mid-access -> PSEL, PENABLE, both gnt and timeout_err go 0 asynchronously; the first tie after release grants m0.
